axil_cfg_regfile: RTL and testbench

- AXI-Lite slave register file sitting directly downstream of the structure-to-AXI-Lite bridge; terminates AW/W/B/AR/R channels and exposes configuration registers to the SAURIA control logic.
- Full handshake compliance: AW and W may arrive in any order or cycle; B and R responses are held until accepted.
- Out-of-window accesses return DECERR.

---
 rtl/axil_cfg_regfile.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_axil_cfg_regfile.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cfg_regfile.sv
// -----------------------------------------------------------------------------
// axil_cfg_regfile
//
// AXI-Lite slave register file. It terminates the AW/W/B and AR/R channels and
// exposes NUM_REGS word-spaced 32-bit read/write configuration registers to the
// SAURIA control logic.
//
// Write path: AW and W are accepted independently, in any order or in the same
// cycle, into single-entry holding buffers. On the first cycle in which both
// buffers are full, the write commits: strobed bytes are updated at the end of
// that cycle and wr_pulse_o[idx] is high during it. The B response is then
// held until b_ready_i.
//
// Read path: an AR handshake captures the current register value (the value
// before any write committing at that same edge) into r_data_o. The R
// response is held until r_ready_i. The read and write paths are independent.
//
// Addresses below BASE_ADDR or at or beyond BASE_ADDR + 4*NUM_REGS get DECERR.
// Writes to them change nothing, and reads of them return zero data.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   aw_addr_i/aw_prot_i/aw_valid_i/aw_ready_o   write address channel
//   w_data_i/w_strb_i/w_valid_i/w_ready_o       write data channel
//   b_resp_o/b_valid_o/b_ready_i                write response channel
//   ar_addr_i/ar_prot_i/ar_valid_i/ar_ready_o   read address channel
//   r_data_o/r_resp_o/r_valid_o/r_ready_i       read data channel
//   regs_o      flattened registers, reg k at bits [32k+31:32k]
//   wr_pulse_o  one-cycle pulse per register on an OKAY write commit
//   The aw_prot_i and ar_prot_i inputs are accepted but ignored.
// -----------------------------------------------------------------------------
module axil_cfg_regfile #(
  parameter int unsigned                 AXI_ADDR_WIDTH = 32,
  parameter int unsigned                 AXI_DATA_WIDTH = 32,
  parameter int unsigned                 NUM_REGS       = 16,
  parameter logic [AXI_ADDR_WIDTH-1:0]   BASE_ADDR      = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,

  input  logic [AXI_ADDR_WIDTH-1:0]      aw_addr_i,
  input  logic [2:0]                     aw_prot_i,
  input  logic                           aw_valid_i,
  output logic                           aw_ready_o,

  input  logic [AXI_DATA_WIDTH-1:0]      w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0]    w_strb_i,
  input  logic                           w_valid_i,
  output logic                           w_ready_o,

  output logic [1:0]                     b_resp_o,
  output logic                           b_valid_o,
  input  logic                           b_ready_i,

  input  logic [AXI_ADDR_WIDTH-1:0]      ar_addr_i,
  input  logic [2:0]                     ar_prot_i,
  input  logic                           ar_valid_i,
  output logic                           ar_ready_o,

  output logic [AXI_DATA_WIDTH-1:0]      r_data_o,
  output logic [1:0]                     r_resp_o,
  output logic                           r_valid_o,
  input  logic                           r_ready_i,

  output logic [NUM_REGS*32-1:0]         regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (AXI_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("axil_cfg_regfile: only AXI_DATA_WIDTH = 32 is supported");
  end
  if (NUM_REGS < 1 || NUM_REGS > 256) begin : g_bad_num_regs
    $error("axil_cfg_regfile: NUM_REGS must be in 1..256");
  end

  // ---------------------------------------------------------------------------
  // Local types and constants
  // ---------------------------------------------------------------------------
  localparam int unsigned NUM_BYTES = AXI_DATA_WIDTH / 8;
  localparam int unsigned IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [AXI_ADDR_WIDTH-1:0] NUM_REGS_A = AXI_ADDR_WIDTH'(NUM_REGS);

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_e;

  // ---------------------------------------------------------------------------
  // Address decode
  // The offset wraps modulo 2^AXI_ADDR_WIDTH, so the explicit addr >= BASE_ADDR
  // term is needed to reject addresses that sit just below the window.
  // addr[1:0] is dropped by the word shift.
  // ---------------------------------------------------------------------------
  function automatic logic addr_hit(input logic [AXI_ADDR_WIDTH-1:0] addr);
    logic [AXI_ADDR_WIDTH-1:0] word;
    word = (addr - BASE_ADDR) >> 2;
    return (addr >= BASE_ADDR) && (word < NUM_REGS_A);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
    logic [AXI_ADDR_WIDTH-1:0] word;
    word = (addr - BASE_ADDR) >> 2;
    return IDX_W'(word);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];

  w_state_e                  w_state;
  logic                      aw_held;
  logic                      w_held;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [AXI_DATA_WIDTH-1:0] w_data_q;
  logic [NUM_BYTES-1:0]      w_strb_q;
  logic                      b_valid_q;
  resp_e                     b_resp_q;

  r_state_e                  r_state;
  logic                      r_valid_q;
  resp_e                     r_resp_q;
  logic [AXI_DATA_WIDTH-1:0] r_data_q;

  // ---------------------------------------------------------------------------
  // Handshakes and commit qualification
  // Ready outputs are derived from registered state, so they never depend
  // combinationally on the valid inputs. They are forced low during reset.
  // ---------------------------------------------------------------------------
  assign aw_ready_o = !rst_i && (w_state == W_IDLE) && !aw_held;
  assign w_ready_o  = !rst_i && (w_state == W_IDLE) && !w_held;
  assign ar_ready_o = !rst_i && (r_state == R_IDLE);

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  assign aw_hs = aw_valid_i && aw_ready_o;
  assign w_hs  = w_valid_i  && w_ready_o;
  assign ar_hs = ar_valid_i && ar_ready_o;

  // A write commits in the first cycle where both buffers are already full.
  // Both readies are low in that cycle, so no new beat can collide with it.
  logic             commit;
  logic             w_hit;
  logic [IDX_W-1:0] w_idx;
  assign commit = (w_state == W_IDLE) && aw_held && w_held;
  assign w_hit  = addr_hit(aw_addr_q);
  assign w_idx  = addr_idx(aw_addr_q);

  logic             r_hit;
  logic [IDX_W-1:0] r_idx;
  assign r_hit = addr_hit(ar_addr_i);
  assign r_idx = addr_idx(ar_addr_i);

  // ---------------------------------------------------------------------------
  // Write FSM: AW/W holding buffers and B channel
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_addr_q <= aw_addr_i;
            aw_held   <= 1'b1;
          end
          if (w_hs) begin
            w_data_q <= w_data_i;
            w_strb_q <= w_strb_i;
            w_held   <= 1'b1;
          end
          if (commit) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            b_valid_q <= 1'b1;
            b_resp_q  <= w_hit ? RESP_OKAY : RESP_DECERR;
            w_state   <= W_RESP;
          end
        end
        W_RESP: begin
          if (b_ready_i) begin
            b_valid_q <= 1'b0;
            b_resp_q  <= RESP_OKAY;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign b_valid_o = b_valid_q;
  assign b_resp_o  = b_resp_q;

  // ---------------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------------
  // NOTE: this array is architecturally visible configuration state that must
  // read as zero after reset, so it is built from resettable flops rather
  // than a RAM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else if (commit && w_hit) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (w_strb_q[b]) begin
          regs_q[w_idx][8*b +: 8] <= w_data_q[8*b +: 8];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_o
    assign regs_o[32*k +: 32] = regs_q[k];
  end

  // The pulse marks the commit cycle itself, which is the cycle before the
  // new value appears on regs_o. A write of strobe 0 still pulses.
  // NOTE: every output of this always_comb block gets a default first, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    wr_pulse_o = '0;
    if (commit && w_hit && !rst_i) begin
      wr_pulse_o[w_idx] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM: AR capture and R channel
  // regs_q is read before the edge, so a read accepted on the same edge as a
  // write commit returns the old value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= R_IDLE;
      r_valid_q <= 1'b0;
      r_resp_q  <= RESP_OKAY;
      r_data_q  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_valid_q <= 1'b1;
            r_state   <= R_RESP;
            if (r_hit) begin
              r_data_q <= regs_q[r_idx];
              r_resp_q <= RESP_OKAY;
            end else begin
              r_data_q <= '0;
              r_resp_q <= RESP_DECERR;
            end
          end
        end
        R_RESP: begin
          if (r_ready_i) begin
            // Data is returned to zero so r_data_o is 0 whenever r_valid_o is 0.
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= RESP_OKAY;
            r_state   <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign r_valid_o = r_valid_q;
  assign r_resp_o  = r_resp_q;
  assign r_data_o  = r_data_q;

  // Protection attributes carry no meaning for this register file.
  logic unused_prot;
  assign unused_prot = ^{aw_prot_i, ar_prot_i};

endmodule

// File: tb/tb_axil_cfg_regfile.sv
// -----------------------------------------------------------------------------
// tb_axil_cfg_regfile
//
// Directed bench for axil_cfg_regfile with default parameters. Stimulus tasks
// push the expected B/R responses into queues. Independent monitors pop and
// compare them whenever the DUT completes a response handshake. Register
// contents and write-pulse counts are compared against hand-maintained
// expectations.
// -----------------------------------------------------------------------------
module tb_axil_cfg_regfile;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] DECERR = 2'b11;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  logic         clk;
  logic         rst;
  logic [31:0]  aw_addr_i;
  logic [2:0]   aw_prot_i;
  logic         aw_valid_i;
  logic         aw_ready_o;
  logic [31:0]  w_data_i;
  logic [3:0]   w_strb_i;
  logic         w_valid_i;
  logic         w_ready_o;
  logic [1:0]   b_resp_o;
  logic         b_valid_o;
  logic         b_ready_i;
  logic [31:0]  ar_addr_i;
  logic [2:0]   ar_prot_i;
  logic         ar_valid_i;
  logic         ar_ready_o;
  logic [31:0]  r_data_o;
  logic [1:0]   r_resp_o;
  logic         r_valid_o;
  logic         r_ready_i;
  logic [511:0] regs_o;
  logic [15:0]  wr_pulse_o;

  axil_cfg_regfile dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .aw_addr_i  (aw_addr_i),
    .aw_prot_i  (aw_prot_i),
    .aw_valid_i (aw_valid_i),
    .aw_ready_o (aw_ready_o),
    .w_data_i   (w_data_i),
    .w_strb_i   (w_strb_i),
    .w_valid_i  (w_valid_i),
    .w_ready_o  (w_ready_o),
    .b_resp_o   (b_resp_o),
    .b_valid_o  (b_valid_o),
    .b_ready_i  (b_ready_i),
    .ar_addr_i  (ar_addr_i),
    .ar_prot_i  (ar_prot_i),
    .ar_valid_i (ar_valid_i),
    .ar_ready_o (ar_ready_o),
    .r_data_o   (r_data_o),
    .r_resp_o   (r_resp_o),
    .r_valid_o  (r_valid_o),
    .r_ready_i  (r_ready_i),
    .regs_o     (regs_o),
    .wr_pulse_o (wr_pulse_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  logic [1:0]  b_exp_q [$];
  r_exp_t      r_exp_q [$];
  logic [31:0] mdl [16];
  int          pulse_cnt [16];
  int          exp_pulse [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (mon_en && b_valid_o && b_ready_i) begin
      if (b_exp_q.size() == 0) begin
        check("b_unexpected", {63'd0, b_valid_o}, 64'd0);
      end else begin
        check("b_resp", {62'd0, b_resp_o}, {62'd0, b_exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    r_exp_t e;
    if (mon_en && r_valid_o && r_ready_i) begin
      if (r_exp_q.size() == 0) begin
        check("r_unexpected", {63'd0, r_valid_o}, 64'd0);
      end else begin
        e = r_exp_q.pop_front();
        check("r_data", {32'd0, r_data_o}, {32'd0, e.data});
        check("r_resp", {62'd0, r_resp_o}, {62'd0, e.resp});
      end
    end
    if (mon_en && !r_valid_o) begin
      check("r_data_idle", {32'd0, r_data_o}, 64'd0);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 16; k++) begin
        if (wr_pulse_o[k]) pulse_cnt[k]++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic expect_b(input logic [31:0] addr, input logic [1:0] resp);
    b_exp_q.push_back(resp);
    if (resp == OKAY) exp_pulse[int'(addr[5:2])]++;
  endtask

  task automatic send_aw(input logic [31:0] addr);
    logic go;
    aw_addr_i  = addr;
    aw_valid_i = 1'b1;
    for (int n = 0; n < 40 && aw_valid_i; n++) begin
      @(negedge clk);
      go = aw_ready_o;
      @(posedge clk); #1;
      if (go) aw_valid_i = 1'b0;
    end
    check("aw_accept", {63'd0, aw_valid_i}, 64'd0);
    aw_valid_i = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    logic go;
    w_data_i  = data;
    w_strb_i  = strb;
    w_valid_i = 1'b1;
    for (int n = 0; n < 40 && w_valid_i; n++) begin
      @(negedge clk);
      go = w_ready_o;
      @(posedge clk); #1;
      if (go) w_valid_i = 1'b0;
    end
    check("w_accept", {63'd0, w_valid_i}, 64'd0);
    w_valid_i = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp);
    expect_b(addr, resp);
    fork
      send_aw(addr);
      send_w(data, strb);
    join
  endtask

  // The response is expected exactly one cycle after the AR handshake.
  task automatic axi_read(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp);
    logic  go;
    r_exp_t e;
    e.data = data;
    e.resp = resp;
    r_exp_q.push_back(e);
    ar_addr_i  = addr;
    ar_valid_i = 1'b1;
    for (int n = 0; n < 40 && ar_valid_i; n++) begin
      @(negedge clk);
      go = ar_ready_o;
      @(posedge clk); #1;
      if (go) ar_valid_i = 1'b0;
    end
    check("ar_accept", {63'd0, ar_valid_i}, 64'd0);
    ar_valid_i = 1'b0;
    @(negedge clk);
    check("r_latency", {63'd0, r_valid_o}, 64'd1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (b_exp_q.size() == 0 && r_exp_q.size() == 0 && !b_valid_o && !r_valid_o) break;
    end
    check("idle_pending", 64'(b_exp_q.size() + r_exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_regs();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("reg%0d", k), {32'd0, regs_o[32*k +: 32]}, {32'd0, mdl[k]});
    end
  endtask

  task automatic check_pulses();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("pulse_cnt%0d", k), 64'(pulse_cnt[k]), 64'(exp_pulse[k]));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst        = 1'b1;
    aw_addr_i  = '0;
    aw_prot_i  = '0;
    aw_valid_i = 1'b0;
    w_data_i   = '0;
    w_strb_i   = '0;
    w_valid_i  = 1'b0;
    b_ready_i  = 1'b1;
    ar_addr_i  = '0;
    ar_prot_i  = '0;
    ar_valid_i = 1'b0;
    r_ready_i  = 1'b1;
    for (int k = 0; k < 16; k++) begin
      mdl[k]       = '0;
      pulse_cnt[k] = 0;
      exp_pulse[k] = 0;
    end

    // Reset state.
    @(negedge clk);
    check("rst_aw_ready", {63'd0, aw_ready_o}, 64'd0);
    check("rst_ar_ready", {63'd0, ar_ready_o}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("idle_aw_ready", {63'd0, aw_ready_o}, 64'd1);
    check("idle_w_ready",  {63'd0, w_ready_o},  64'd1);
    check("idle_ar_ready", {63'd0, ar_ready_o}, 64'd1);
    check("idle_b_valid",  {63'd0, b_valid_o},  64'd0);
    check("idle_r_valid",  {63'd0, r_valid_o},  64'd0);
    check("idle_pulse",    {48'd0, wr_pulse_o}, 64'd0);
    check_regs();
    @(posedge clk); #1;

    // 1: AW and W together; pulse in the commit cycle, B one cycle later.
    axi_write(32'h08, 32'hDEAD_BEEF, 4'hF, OKAY);
    mdl[2] = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t1_pulse",        {48'd0, wr_pulse_o}, 64'h0004);
    check("t1_b_not_yet",    {63'd0, b_valid_o},  64'd0);
    @(negedge clk);
    check("t1_b_valid",      {63'd0, b_valid_o},  64'd1);
    check("t1_reg2",         {32'd0, regs_o[95:64]}, 64'hDEAD_BEEF);
    wait_idle();
    axi_read(32'h08, 32'hDEAD_BEEF, OKAY);
    wait_idle();
    check("t1_pulse_once", 64'(pulse_cnt[2]), 64'd1);

    // 2: W arrives 3 cycles ahead of AW, partial strobe.
    axi_write(32'h04, 32'hAAAA_AAAA, 4'hF, OKAY);
    wait_idle();
    expect_b(32'h04, OKAY);
    send_w(32'h1122_3344, 4'b0101);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_w_ready_held", {63'd0, w_ready_o},  64'd0);
      check("t2_aw_ready",     {63'd0, aw_ready_o}, 64'd1);
    end
    @(posedge clk); #1;
    send_aw(32'h04);
    @(negedge clk);
    check("t2_w_ready_commit", {63'd0, w_ready_o}, 64'd0);
    wait_idle();
    mdl[1] = 32'hAA22_AA44;
    @(negedge clk);
    check("t2_w_ready_back", {63'd0, w_ready_o}, 64'd1);
    check_regs();
    @(posedge clk); #1;

    // 3: B back-pressure for 5 cycles, handshake on the 6th.
    b_ready_i = 1'b0;
    axi_write(32'h10, 32'h0000_1234, 4'hF, OKAY);
    mdl[4] = 32'h0000_1234;
    for (int n = 0; n < 20 && !b_valid_o; n++) @(negedge clk);
    check("t3_b_seen", {63'd0, b_valid_o}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("t3_b_valid_hold", {63'd0, b_valid_o},  64'd1);
      check("t3_b_resp_hold",  {62'd0, b_resp_o},   64'd0);
      check("t3_aw_ready_low", {63'd0, aw_ready_o}, 64'd0);
    end
    @(posedge clk); #1;
    b_ready_i = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("t3_b_done", {63'd0, b_valid_o}, 64'd0);
    wait_idle();

    // 4: out-of-window read and write both get DECERR.
    fork
      axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, DECERR);
      axi_read(32'h40, 32'h0, DECERR);
    join
    wait_idle();
    check_regs();
    check_pulses();

    // 5: read and write to the same register in the same cycle, and a read
    //    accepted on the commit edge; both see the old value.
    axi_write(32'h0C, 32'h5, 4'hF, OKAY);
    wait_idle();
    fork
      axi_write(32'h0C, 32'h9, 4'hF, OKAY);
      axi_read(32'h0C, 32'h5, OKAY);
    join
    wait_idle();
    axi_read(32'h0C, 32'h9, OKAY);
    wait_idle();
    axi_write(32'h0C, 32'h5, 4'hF, OKAY);
    wait_idle();
    fork
      axi_write(32'h0C, 32'hA, 4'hF, OKAY);
      begin
        @(posedge clk); #1;
        axi_read(32'h0C, 32'h5, OKAY);
      end
    join
    wait_idle();
    axi_read(32'h0C, 32'hA, OKAY);
    wait_idle();
    mdl[3] = 32'hA;
    // A zero-strobe write is OKAY, pulses, and leaves data unchanged.
    axi_write(32'h0C, 32'hFFFF_FFFF, 4'h0, OKAY);
    wait_idle();
    check_regs();
    check_pulses();

    // 6: reset after the AW handshake, before W: no B, regs cleared.
    send_aw(32'h10);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_aw_ready", {63'd0, aw_ready_o}, 64'd0);
    check("t6_rst_w_ready",  {63'd0, w_ready_o},  64'd0);
    check("t6_rst_ar_ready", {63'd0, ar_ready_o}, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 16; k++) mdl[k] = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_no_b",       {63'd0, b_valid_o},  64'd0);
      check("t6_aw_ready",   {63'd0, aw_ready_o}, 64'd1);
      check("t6_w_ready",    {63'd0, w_ready_o},  64'd1);
    end
    check_regs();
    @(posedge clk); #1;
    axi_write(32'h14, 32'hCAFE_F00D, 4'hF, OKAY);
    mdl[5] = 32'hCAFE_F00D;
    wait_idle();
    axi_read(32'h14, 32'hCAFE_F00D, OKAY);
    wait_idle();
    check_regs();
    check_pulses();

    check("b_queue_empty", 64'(b_exp_q.size()), 64'd0);
    check("r_queue_empty", 64'(r_exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
